// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - states, opcodes and datapath select encodings for multicycle_control (MCU_MULDIV_EN adds MULWAIT)
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
`ifdef MCU_MULDIV_EN
    , ST_MULWAIT = 3'd7
`endif
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_BRANCH = 3'd1;
  localparam logic [2:0] ALU_RFUNCT = 3'd2;
  localparam logic [2:0] ALU_IFUNCT = 3'd3;
  localparam logic [2:0] ALU_PASSB  = 3'd4;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;

  localparam logic [1:0] SRCA_RS1   = 2'd0;
  localparam logic [1:0] SRCA_PC    = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // R-type legality depends on funct7; every other supported opcode is legal as a whole
  function automatic logic is_legal(input logic [6:0] op, input logic [6:0] f7);
    logic legal;
    case (op)
      OP_R: begin
        legal = (f7 == F7_BASE) || (f7 == F7_ALT);
`ifdef MCU_MULDIV_EN
        legal = legal || (f7 == F7_MULDIV);
`endif
      end
      OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts unanswered memory request cycles and flags the timeout
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  logic [7:0] count;

  // Count request cycles left unanswered; restart outside memory phases and on every completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || ready) begin
      count <= '0;
    end else if (req) begin
      count <= count + 8'd1;
    end
  end

  // The wait cycle that would bring the count to the limit is the last one tolerated; ready wins
  assign timeout = req && !ready && (({1'b0, count} + 9'd1) == 9'(TIMEOUT_CYC));

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - RV32I multicycle main controller FSM (option: MCU_MULDIV_EN)
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [6:0]         funct7,
  input  logic               branch_taken,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_is_fetch,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               target_write,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic               illegal,
  output logic               mem_fault,
  output logic               busy
`ifdef MCU_MULDIV_EN
  ,
  output logic               muldiv_start,
  input  logic               muldiv_done
`endif
);

  state_t     state;
  logic [6:0] op_q;
  logic [2:0] op_sel;
  logic       timeout;
  logic       timer_clear;
`ifdef MCU_MULDIV_EN
  logic       mul_q;
`endif

  // Counter is held clear outside FETCH and MEM, so it always starts from zero on entry
  assign timer_clear = !((state == ST_FETCH) || (state == ST_MEM));

  mem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .req     (mem_req),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  // State sequencing, opcode hold register and sticky trap flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      op_q      <= '0;
      illegal   <= 1'b0;
      mem_fault <= 1'b0;
`ifdef MCU_MULDIV_EN
      mul_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RESET: state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) begin
            state <= ST_DECODE;
          end else if (timeout) begin
            state     <= ST_TRAP;
            mem_fault <= 1'b1;
          end
        end
        ST_DECODE: begin
          op_q <= opcode;
`ifdef MCU_MULDIV_EN
          mul_q <= (opcode == OP_R) && (funct7 == F7_MULDIV);
`endif
          if (is_legal(opcode, funct7)) begin
            state <= ST_EXEC;
          end else begin
            state   <= ST_TRAP;
            illegal <= 1'b1;
          end
        end
        ST_EXEC: begin
          case (op_q)
            OP_R: begin
`ifdef MCU_MULDIV_EN
              state <= mul_q ? ST_MULWAIT : ST_WB;
`else
              state <= ST_WB;
`endif
            end
            OP_IMM, OP_LUI, OP_AUIPC: state <= ST_WB;
            OP_LOAD, OP_STORE:        state <= ST_MEM;
            default:                  state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            state <= (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
          end else if (timeout) begin
            state     <= ST_TRAP;
            mem_fault <= 1'b1;
          end
        end
        ST_WB: state <= ST_FETCH;
`ifdef MCU_MULDIV_EN
        ST_MULWAIT: if (muldiv_done) state <= ST_WB;
`endif
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_RESET;
      endcase
    end
  end

  assign alu_op = ALUOP_W'(op_sel);

  // Datapath controls decoded from state, held opcode and the handshake inputs of this cycle
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    alu_src_a    = SRCA_RS1;
    alu_src_b    = SRCB_RS2;
    op_sel       = ALU_ADD;
    target_write = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    busy         = 1'b1;
`ifdef MCU_MULDIV_EN
    muldiv_start = 1'b0;
`endif
    case (state)
      ST_RESET: busy = 1'b0;
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
        end
      end
      ST_DECODE: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_IMM;
        op_sel       = ALU_ADD;
        target_write = 1'b1;
      end
      ST_EXEC: begin
        case (op_q)
          OP_R: begin
            op_sel = ALU_RFUNCT;
`ifdef MCU_MULDIV_EN
            muldiv_start = mul_q;
`endif
          end
          OP_IMM: begin
            op_sel    = ALU_IFUNCT;
            alu_src_b = SRCB_IMM;
          end
          OP_LOAD, OP_STORE: alu_src_b = SRCB_IMM;
          OP_BRANCH: begin
            op_sel = ALU_BRANCH;
            if (branch_taken) begin
              pc_write = 1'b1;
              pc_src   = PC_TARGET;
            end
          end
          OP_JAL: begin
            pc_write  = 1'b1;
            pc_src    = PC_TARGET;
            reg_write = 1'b1;
            wb_sel    = WB_PC4;
          end
          OP_JALR: begin
            alu_src_b = SRCB_IMM;
            pc_write  = 1'b1;
            pc_src    = PC_ALU;
            reg_write = 1'b1;
            wb_sel    = WB_PC4;
          end
          OP_LUI: begin
            alu_src_a = SRCA_ZERO;
            op_sel    = ALU_PASSB;
          end
          OP_AUIPC: alu_src_a = SRCA_OLDPC;
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_STORE);
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (op_q == OP_LOAD) ? WB_MDR : WB_ALU;
      end
      ST_TRAP: busy = 1'b0;
      default: busy = 1'b1;
    endcase
  end

endmodule
